shift_cmd_fifo: RTL and testbench
=================================

SHIFT_CMD_FIFO -- requirements
Module: shift_cmd_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of command entries; the block SHALL support power-of-two values 2..16.
REQ-002 Parameter WIDTH, default 8, command word width in bits; the block SHALL treat the word as opaque payload.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  producer offers in_data this cycle.
REQ-006 Port in_ready  output  1  block can accept a command this cycle.
REQ-007 Port in_data  input  WIDTH  command word: [3:0] shift operand, [5:4] shift amount, [6] direction (0 left, 1 right), [7] rotate (1) / logical (0).
REQ-008 Port out_valid  output  1  head command is presented to the downstream 4-bit barrel shifter.
REQ-009 Port out_ready  input  1  shifter consumes the head command this cycle.
REQ-010 Port out_data  output  WIDTH  head command word.
REQ-011 Port level  output  clog2(DEPTH)+1  number of stored commands.
REQ-012 Port ovf  output  1  sticky flag: a command was offered while the block was full.
REQ-013 Port clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-014 The block SHALL be a first-word-fall-through circular buffer with a write pointer, a read pointer and an occupancy counter.
REQ-015 Push SHALL occur when in_valid && in_ready: in_data is written at the write pointer, and the write pointer advances modulo DEPTH.
REQ-016 Pop SHALL occur when out_valid && out_ready: the read pointer advances modulo DEPTH.
REQ-017 in_ready SHALL equal (level != DEPTH) and SHALL be combinationally independent of out_ready (no full-bypass).
REQ-018 out_valid SHALL equal (level != 0), and out_data SHALL equal the entry at the read pointer when out_valid is 1, else all zeros.
REQ-019 Latency: a command pushed into an empty block SHALL appear on out_valid/out_data on the next cycle; there is no same-cycle pass-through.
REQ-020 level SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on no transfer.
REQ-021 When the block is full, in_ready SHALL be 0, and a simultaneous pop SHALL only free the slot for the following cycle.
REQ-022 When the block is empty, out_ready SHALL be ignored, and neither the pointers nor level SHALL change.
REQ-023 Commands SHALL leave in exact push order across pointer wrap-around, with no loss or duplication.
REQ-024 in_valid && !in_ready SHALL set ovf on the next edge, and the offered word SHALL be dropped without modifying state.
REQ-025 clr_ovf SHALL clear ovf on the next edge; if a set condition and clr_ovf coincide, the set SHALL win.
REQ-026 The payload SHALL never be modified, and in_data fields SHALL not affect control behaviour.

Reset
REQ-027 While rst_n is 0, the pointers, level and ovf SHALL be 0 immediately (asynchronously); out_valid, out_data and ovf SHALL therefore be 0, and in_ready SHALL be 1.
REQ-028 Storage contents SHALL not require reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored commands; the first push after release SHALL be the first command output.
REQ-030 Release of rst_n SHALL be honoured on the next rising clk edge, and a push in that cycle SHALL be accepted.

Verification
REQ-031 Reset, then push 0x15 with out_ready=0 -> next cycle out_valid=1, out_data=0x15, level=1.
REQ-032 Push 0x01,0x22,0x43,0x84 with out_ready=0 -> level=4, in_ready=0; offering 0x99 -> ovf=1, level stays 4; drain -> outputs are 0x01,0x22,0x43,0x84 in order, with no 0x99.
REQ-033 Keep the block full and assert in_valid and out_ready together for one cycle -> one pop, no push, level=3; the next cycle the push is accepted and level=4.
REQ-034 Stream 10 commands 0xA0..0xA9 with out_ready=1 every cycle -> a single entry in flight, level stays at most 1, outputs are identical and in order across the pointer wrap.
REQ-035 Fill to 3 entries, then pulse rst_n low between clock edges -> out_valid=0, level=0 and ovf=0 immediately; after release, push 0x3C -> output 0x3C first.
REQ-036 Set ovf, then assert clr_ovf together with an overflowing push -> ovf stays 1; the next cycle assert clr_ovf alone -> ovf=0.

Source files
------------

// File: rtl/shift_cmd_fifo.sv
// First-word-fall-through command FIFO feeding the 4-bit barrel shifter.
// Payload is opaque; ovf is a sticky flag for pushes offered while full.
module shift_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != LW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = count;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // A new overflow outranks a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid && !in_ready) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Directed bench for shift_cmd_fifo.
// Expected values are hand-computed per vector.
module tb_shift_cmd_fifo;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] level;
    logic       ovf;
    logic       clr_ovf;

    int n_cmp;
    int n_err;

    shift_cmd_fifo #(.DEPTH(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] w);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_data), 32'(w));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;

        tick();
        chk("rst_ovld", 32'(out_valid), 32'd0);
        chk("rst_lvl", 32'(level), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_irdy", 32'(in_ready), 32'd1);
        chk("rst_odat", 32'(out_data), 32'd0);

        // release and push in the same cycle
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h15;
        #1;
        chk("no_pass", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("p15_vld", 32'(out_valid), 32'd1);
        chk("p15_dat", 32'(out_data), 32'h15);
        chk("p15_lvl", 32'(level), 32'd1);
        pop_chk("p15_pop", 8'h15);
        chk("p15_empty", 32'(level), 32'd0);

        // empty: out_ready ignored
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("emp_lvl", 32'(level), 32'd0);

        // fill, overflow, drain
        push(8'h01);
        push(8'h22);
        push(8'h43);
        push(8'h84);
        chk("full_lvl", 32'(level), 32'd4);
        chk("full_irdy", 32'(in_ready), 32'd0);
        push(8'h99);
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_lvl", 32'(level), 32'd4);
        pop_chk("dr0", 8'h01);
        pop_chk("dr1", 8'h22);
        pop_chk("dr2", 8'h43);
        pop_chk("dr3", 8'h84);
        chk("dr_empty", 32'(out_valid), 32'd0);
        chk("dr_odat", 32'(out_data), 32'd0);
        chk("dr_lvl", 32'(level), 32'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);

        // full with simultaneous push+pop
        push(8'hB0);
        push(8'hB1);
        push(8'hB2);
        push(8'hB3);
        in_valid  = 1'b1;
        in_data   = 8'hB4;
        out_ready = 1'b1;
        #1;
        chk("fb_irdy", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        chk("fb_lvl3", 32'(level), 32'd3);
        chk("fb_head", 32'(out_data), 32'hB1);
        chk("fb_irdy1", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("fb_lvl4", 32'(level), 32'd4);
        pop_chk("fb0", 8'hB1);
        pop_chk("fb1", 8'hB2);
        pop_chk("fb2", 8'hB3);
        pop_chk("fb3", 8'hB4);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // streaming across pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            tick();
            chk("st_vld", 32'(out_valid), 32'd1);
            chk("st_dat", 32'(out_data), 32'hA0 + 32'(i));
            chk("st_lvl", 32'(level), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("st_end", 32'(level), 32'd0);

        // async reset mid-operation with ovf set
        push(8'hC0);
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        push(8'hC4);
        pop_chk("ar_pop", 8'hC0);
        chk("ar_lvl3", 32'(level), 32'd3);
        chk("ar_ovf1", 32'(ovf), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_ovld", 32'(out_valid), 32'd0);
        chk("ar_lvl", 32'(level), 32'd0);
        chk("ar_ovf", 32'(ovf), 32'd0);
        chk("ar_irdy", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        push(8'h3C);
        chk("ar_lvl1", 32'(level), 32'd1);
        pop_chk("ar_first", 8'h3C);
        chk("ar_empty", 32'(level), 32'd0);

        // set wins over clear
        push(8'hD0);
        push(8'hD1);
        push(8'hD2);
        push(8'hD3);
        push(8'hEE);
        chk("sw_set", 32'(ovf), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'hEF;
        clr_ovf  = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("sw_win", 32'(ovf), 32'd1);
        tick();
        clr_ovf = 1'b0;
        chk("sw_clr", 32'(ovf), 32'd0);
        chk("sw_lvl", 32'(level), 32'd4);
        pop_chk("sw0", 8'hD0);
        pop_chk("sw1", 8'hD1);
        pop_chk("sw2", 8'hD2);
        pop_chk("sw3", 8'hD3);
        chk("sw_empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
